// File: rtl/reloj_bcd.sv
`default_nettype none
// ============================================================================
// Module   : reloj_bcd
// Purpose  : 24-hour HH:MM BCD clock with RUN/SET modes, drives digit display
// Revision : 1.0 - initial release
// ============================================================================
module reloj_bcd #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        set_btn,
    input  logic        inc_hr,
    input  logic        inc_min,
    output logic [15:0] numeros,
    output logic        sec_pulse,
    output logic        modo_set
);

    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICKS_PER_SEC - 1);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t               r_state;
    logic [PRESC_W-1:0]   r_presc;
    logic [5:0]           r_sec;
    logic [3:0]           r_hr_t, r_hr_u, r_min_t, r_min_u;

    // Button conditioning: bit 0 = set_btn, bit 1 = inc_hr, bit 2 = inc_min
    logic [2:0] r_btn_s1, r_btn_s2, r_btn_prev;
    logic [2:0] w_btn_in, w_btn_pulse;
    logic       w_set_p, w_hr_p, w_min_p;

    assign w_btn_in    = {inc_min, inc_hr, set_btn};
    assign w_btn_pulse = r_btn_s2 & ~r_btn_prev;
    assign w_set_p     = w_btn_pulse[0];
    assign w_hr_p      = w_btn_pulse[1];
    assign w_min_p     = w_btn_pulse[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_s1   <= 3'b000;
            r_btn_s2   <= 3'b000;
            r_btn_prev <= 3'b000;
        end else begin
            r_btn_s1   <= w_btn_in;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
        end
    end

    // Next-value BCD increments, shared by RUN carries and SET buttons
    logic [3:0] w_min_t_nx, w_min_u_nx, w_hr_t_nx, w_hr_u_nx;
    logic       w_min_carry;

    always_comb begin
        w_min_carry = 1'b0;
        w_min_t_nx  = r_min_t;
        w_min_u_nx  = r_min_u + 4'd1;
        if (r_min_u == 4'd9) begin
            w_min_u_nx = 4'd0;
            if (r_min_t == 4'd5) begin
                w_min_t_nx  = 4'd0;
                w_min_carry = 1'b1;
            end else begin
                w_min_t_nx = r_min_t + 4'd1;
            end
        end
    end

    always_comb begin
        w_hr_t_nx = r_hr_t;
        w_hr_u_nx = r_hr_u + 4'd1;
        if (r_hr_t == 4'd2 && r_hr_u == 4'd3) begin
            w_hr_t_nx = 4'd0;
            w_hr_u_nx = 4'd0;
        end else if (r_hr_u == 4'd9) begin
            w_hr_t_nx = r_hr_t + 4'd1;
            w_hr_u_nx = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            modo_set  <= 1'b0;
            r_presc   <= '0;
            r_sec     <= 6'd0;
            r_hr_t    <= 4'd0;
            r_hr_u    <= 4'd0;
            r_min_t   <= 4'd0;
            r_min_u   <= 4'd0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            if (w_set_p) begin
                r_state  <= (r_state == ST_RUN) ? ST_SET : ST_RUN;
                modo_set <= (r_state == ST_RUN);
            end
            if (r_state == ST_SET) begin
                // Minutes wrap without carrying into hours while setting
                if (w_min_p) begin
                    r_min_t <= w_min_t_nx;
                    r_min_u <= w_min_u_nx;
                end
                if (w_hr_p) begin
                    r_hr_t <= w_hr_t_nx;
                    r_hr_u <= w_hr_u_nx;
                end
                if (w_set_p) begin
                    r_sec   <= 6'd0;
                    r_presc <= '0;
                end
            end else if (en) begin
                if (r_presc == c_presc_max) begin
                    r_presc   <= '0;
                    sec_pulse <= 1'b1;
                    if (r_sec == 6'd59) begin
                        r_sec   <= 6'd0;
                        r_min_t <= w_min_t_nx;
                        r_min_u <= w_min_u_nx;
                        if (w_min_carry) begin
                            r_hr_t <= w_hr_t_nx;
                            r_hr_u <= w_hr_u_nx;
                        end
                    end else begin
                        r_sec <= r_sec + 6'd1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign numeros = {r_min_u, r_min_t, r_hr_u, r_hr_t};

endmodule
`default_nettype wire

// File: tb/tb_reloj_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_reloj_bcd
// Purpose  : Directed, table-driven self-checking bench for reloj_bcd
// Revision : 1.0 - initial release
// ============================================================================
module tb_reloj_bcd;

    logic        clk;
    logic        reset;
    logic        en;
    logic        set_btn;
    logic        inc_hr;
    logic        inc_min;
    logic [15:0] numeros;
    logic        sec_pulse;
    logic        modo_set;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    reloj_bcd #(
        .TICKS_PER_SEC(4),
        .PRESC_W      (26)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .set_btn  (set_btn),
        .inc_hr   (inc_hr),
        .inc_min  (inc_min),
        .numeros  (numeros),
        .sec_pulse(sec_pulse),
        .modo_set (modo_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hr;
        logic        mn;
        int          reps;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Digits must always stay legal BCD and within 23:59
    logic w_legal;
    assign w_legal = (numeros[3:0] <= 4'd2) && (numeros[7:4] <= 4'd9) &&
                     (numeros[11:8] <= 4'd5) && (numeros[15:12] <= 4'd9) &&
                     ((numeros[3:0] < 4'd2) || (numeros[7:4] <= 4'd3));

    always @(negedge clk) begin
        if (!reset) begin
            chk("bcd_legal", {31'd0, w_legal}, 32'd1);
            if (sec_pulse) pulse_cnt++;
        end
    end

    initial begin : main
        int saved_pulses;
        bit found;

        tbl[0]  = '{1'b0, 1'b1, 1,  16'h2000};
        tbl[1]  = '{1'b1, 1'b0, 15, 16'h2051};
        tbl[2]  = '{1'b1, 1'b0, 13, 16'h2040};
        tbl[3]  = '{1'b0, 1'b1, 57, 16'h9540};
        tbl[4]  = '{1'b0, 1'b1, 1,  16'h0040};
        tbl[5]  = '{1'b0, 1'b1, 9,  16'h9040};
        tbl[6]  = '{1'b0, 1'b1, 1,  16'h0140};
        tbl[7]  = '{1'b1, 1'b0, 6,  16'h0101};
        tbl[8]  = '{1'b0, 1'b1, 49, 16'h9501};
        tbl[9]  = '{1'b1, 1'b1, 1,  16'h0011};
        tbl[10] = '{1'b1, 1'b0, 9,  16'h0002};
        tbl[11] = '{1'b1, 1'b0, 3,  16'h0032};
        tbl[12] = '{1'b0, 1'b1, 58, 16'h8532};

        reset = 1'b1; en = 1'b1; set_btn = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
        step(3);
        chk("rst_numeros", {16'd0, numeros}, 32'h0);
        chk("rst_sec_pulse", {31'd0, sec_pulse}, 32'd0);
        chk("rst_modo_set", {31'd0, modo_set}, 32'd0);

        // Free run for one minute: pulse on every 4th edge
        reset = 1'b0;
        for (int i = 1; i <= 240; i++) begin
            step(1);
            chk($sformatf("run_pulse_c%0d", i), {31'd0, sec_pulse}, {31'd0, (i % 4 == 0)});
        end
        chk("one_minute", {16'd0, numeros}, 32'h1000);

        // Freeze with en=0 after two prescaler counts
        step(2);
        en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            chk("frozen_pulse", {31'd0, sec_pulse}, 32'd0);
            chk("frozen_numeros", {16'd0, numeros}, 32'h1000);
        end
        en = 1'b1;
        step(1);
        chk("resume_c1", {31'd0, sec_pulse}, 32'd0);
        step(1);
        chk("resume_c2", {31'd0, sec_pulse}, 32'd1);

        // Enter SET: effect on the third edge, held button toggles once
        set_btn = 1'b1;
        step(2);
        chk("set_entry_e2", {31'd0, modo_set}, 32'd0);
        step(1);
        chk("set_entry_e3", {31'd0, modo_set}, 32'd1);
        saved_pulses = pulse_cnt;
        step(10);
        chk("set_held", {31'd0, modo_set}, 32'd1);
        set_btn = 1'b0;
        step(3);

        for (int v = 0; v < 13; v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                inc_hr  = tbl[v].hr;
                inc_min = tbl[v].mn;
                step(3);
                inc_hr  = 1'b0;
                inc_min = 1'b0;
                step(3);
            end
            chk($sformatf("tbl%0d_numeros", v), {16'd0, numeros}, {16'd0, tbl[v].exp});
            chk($sformatf("tbl%0d_modo", v), {31'd0, modo_set}, 32'd1);
        end

        inc_min = 1'b1;
        step(50);
        inc_min = 1'b0;
        step(3);
        chk("hold_inc_min", {16'd0, numeros}, 32'h9532);
        chk("no_pulse_in_set", pulse_cnt, saved_pulses);

        // Exit SET at 23:59, seconds restart from 0 -> rollover at 60th pulse
        set_btn = 1'b1;
        step(2);
        chk("set_exit_e2", {31'd0, modo_set}, 32'd1);
        step(1);
        chk("set_exit_e3", {31'd0, modo_set}, 32'd0);
        set_btn = 1'b0;
        for (int j = 1; j <= 240; j++) begin
            step(1);
            chk($sformatf("roll_pulse_c%0d", j), {31'd0, sec_pulse}, {31'd0, (j % 4 == 0)});
            if (j < 240)
                chk($sformatf("roll_hold_c%0d", j), {16'd0, numeros}, 32'h9532);
            else
                chk("rollover", {16'd0, numeros}, 32'h0);
        end

        inc_min = 1'b1;
        step(3);
        inc_min = 1'b0;
        step(3);
        chk("run_ignores_inc", {16'd0, numeros}, 32'h0);
        chk("run_modo", {31'd0, modo_set}, 32'd0);

        // Wait for the 00:01 tick, then reset asynchronously in that cycle
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            step(1);
            if (sec_pulse === 1'b1 && numeros === 16'h1000) found = 1'b1;
        end
        chk("reach_00_01", {31'd0, found}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_numeros", {16'd0, numeros}, 32'h0);
        chk("async_rst_pulse", {31'd0, sec_pulse}, 32'd0);
        chk("async_rst_modo", {31'd0, modo_set}, 32'd0);
        step(2);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk($sformatf("post_rst_c%0d", i), {31'd0, sec_pulse}, {31'd0, (i == 4)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
